// File: rtl/fp16_sqrt_sequencer.sv
// fp16_sqrt_sequencer: multi-cycle FP16 square root with valid/ready on both sides.
// Specials resolve straight to the output register. Numeric operands run a restoring
// digit recurrence (one root bit per cycle), packed into the output register on the
// last iteration. Optional macro FP16_SQRT_ROUND_EN: 12 iterations with
// round-to-nearest-even; without it, 11 iterations and truncation.
module fp16_sqrt_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

`ifdef FP16_SQRT_ROUND_EN
    localparam logic [3:0] N_ITER = 4'd12;
`else
    localparam logic [3:0] N_ITER = 4'd11;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_OUT = 2'd2} state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [33:0]       r_rad;       // radicand, consumed two bits per iteration from the top
    logic [15:0]       r_rem;       // partial remainder
    logic [11:0]       r_root;      // partial root
    logic [3:0]        r_cnt;       // iterations done
    logic signed [6:0] r_exp;       // halved unbiased result exponent
    logic [15:0]       r_out_data;

    logic              w_accept;
    logic              w_last_iter;

    logic [4:0]        w_in_exp;
    logic [9:0]        w_in_frac;
    logic              w_is_special;
    logic [15:0]       w_special_res;
    logic [3:0]        w_clz;
    logic [10:0]       w_norm_mant;
    logic signed [6:0] w_norm_exp;
    logic [11:0]       w_prep_mant;
    logic signed [6:0] w_adj_exp;
    logic signed [6:0] w_half_exp;

    logic [15:0]       w_rem_shift;
    logic [15:0]       w_trial;
    logic [15:0]       w_rem_next;
    logic [11:0]       w_root_next;

    logic signed [6:0] w_exp_out;
    logic signed [6:0] w_biased;
    logic [9:0]        w_pack_frac;
    logic [15:0]       w_packed;
    logic              w_unused;

`ifdef FP16_SQRT_ROUND_EN
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [11:0]       w_mant_sum;
`endif

    // Count leading zeros of a 10-bit fraction (10 when all zero).
    function automatic logic [3:0] clz10(input logic [9:0] f);
        logic [3:0] n;
        n = 4'd10;
        for (int i = 0; i < 10; i++) begin
            if (f[i]) n = 4'(9 - i);
        end
        return n;
    endfunction

    assign w_in_exp    = in_data[14:10];
    assign w_in_frac   = in_data[9:0];
    assign w_accept    = in_valid & in_ready;
    assign w_last_iter = (r_cnt == N_ITER - 4'd1);
    assign out_data    = r_out_data;

    // Classify the operand and prepare mantissa/exponent for the recurrence.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        w_is_special  = 1'b1;
        w_special_res = 16'hFE00;
        if (w_in_exp == 5'h1F && w_in_frac != 10'd0) begin
            w_special_res = 16'hFE00;
        end else if (w_in_exp == 5'd0 && w_in_frac == 10'd0) begin
            w_special_res = in_data;
        end else if (in_data[15]) begin
            w_special_res = 16'hFE00;
        end else if (w_in_exp == 5'h1F) begin
            w_special_res = 16'h7C00;
        end else begin
            w_is_special = 1'b0;
        end

        w_clz = clz10(w_in_frac);
        if (w_in_exp == 5'd0) begin
            w_norm_mant = 11'({1'b0, w_in_frac} << (w_clz + 4'd1));
            w_norm_exp  = -7'sd15 - $signed({3'b000, w_clz});
        end else begin
            w_norm_mant = {1'b1, w_in_frac};
            w_norm_exp  = $signed({2'b00, w_in_exp}) - 7'sd15;
        end

        if (w_norm_exp[0]) begin
            w_prep_mant = {w_norm_mant, 1'b0};
            w_adj_exp   = w_norm_exp - 7'sd1;
        end else begin
            w_prep_mant = {1'b0, w_norm_mant};
            w_adj_exp   = w_norm_exp;
        end
        w_half_exp = w_adj_exp >>> 1;
    end

    // One restoring square-root step: trial subtract of {root, 01}.
    always_comb begin
        w_rem_shift = {r_rem[13:0], r_rad[33:32]};
        w_trial     = {3'b000, r_root[10:0], 2'b01};
        if (w_rem_shift >= w_trial) begin
            w_rem_next  = w_rem_shift - w_trial;
            w_root_next = {r_root[10:0], 1'b1};
        end else begin
            w_rem_next  = w_rem_shift;
            w_root_next = {r_root[10:0], 1'b0};
        end
    end

    // Pack the root produced by the final step into a binary16 result.
    always_comb begin
        w_exp_out = r_exp;
`ifdef FP16_SQRT_ROUND_EN
        w_guard    = w_root_next[0];
        w_sticky   = |w_rem_next;
        w_round_up = w_guard & (w_sticky | w_root_next[1]);
        w_mant_sum = {1'b0, w_root_next[11:1]} + {11'd0, w_round_up};
        if (w_mant_sum[11]) begin
            w_pack_frac = 10'd0;
            w_exp_out   = r_exp + 7'sd1;
        end else begin
            w_pack_frac = w_mant_sum[9:0];
        end
`else
        w_pack_frac = w_root_next[9:0];
`endif
        w_biased = w_exp_out + 7'sd15;
        w_packed = {1'b0, w_biased[4:0], w_pack_frac};
    end

    // Bits that only matter in one configuration, or never reach the result, are gathered here.
`ifdef FP16_SQRT_ROUND_EN
    assign w_unused = &{1'b0, r_root[11], r_rem[15:14], w_biased[6:5], w_mant_sum[10]};
`else
    assign w_unused = &{1'b0, r_root[11], r_rem[15:14], w_biased[6:5]};
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_is_special ? S_OUT : S_ITER;
            S_ITER:  if (w_last_iter) w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_ITER:  busy = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: load on accept, iterate in ITER, capture the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_cnt      <= '0;
            r_exp      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_special) begin
                            r_out_data <= w_special_res;
                        end else begin
                            r_rad  <= {w_prep_mant, 22'd0};
                            r_rem  <= '0;
                            r_root <= '0;
                            r_cnt  <= '0;
                            r_exp  <= w_half_exp;
                        end
                    end
                end
                S_ITER: begin
                    r_rad  <= {r_rad[31:0], 2'b00};
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_last_iter) r_out_data <= w_packed;
                end
                default: ;
            endcase
        end
    end

endmodule
